// File: rtl/mem_wb_stage.sv
// Memory stage and MEM/WB pipeline register: runs the data-memory access over a
// variable-latency req/ack handshake, stalls upstream while busy, registers writeback.
module mem_wb_stage #(
    parameter int TMO_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] alui,
    input  logic [31:0] wdi,
    input  logic [31:0] pcp4i,
    input  logic [4:0]  rdi,
    input  logic        regwi,
    input  logic        memwi,
    input  logic [1:0]  resrci,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata,
    input  logic        dm_ack,
    output logic        stall,
    output logic [31:0] resulto,
    output logic [4:0]  rdo,
    output logic        regwo,
    output logic        err
);

    localparam logic [7:0] TMO_LAST = 8'(TMO_CYCLES - 1);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t      state, state_nxt;
    logic [7:0]  cnt;

    logic [31:0] addr_p1, wdata_p1, pcp4_p1;
    logic        we_p1, regw_p1;
    logic [4:0]  rd_p1;
    logic [1:0]  resrc_p1;

    logic        access, misal, req_ok, tmo_hit, latch_en, err_set;
    logic [31:0] res_nxt;
    logic [4:0]  rd_nxt;
    logic        regw_nxt;

    function automatic logic [31:0] wb_sel(input logic [1:0]  sel,
                                           input logic [31:0] alu,
                                           input logic [31:0] ld,
                                           input logic [31:0] pcp4);
        case (sel)
            2'b00:   return alu;
            2'b01:   return ld;
            2'b10:   return pcp4;
            default: return '0;
        endcase
    endfunction

    // A store that also selects load data is still a store; only alignment gates the request.
    assign access  = memwi | (resrci == 2'b01);
    assign misal   = access & (alui[1:0] != 2'b00);
    assign req_ok  = access & ~misal;
    assign tmo_hit = (state == BUSY) & ~dm_ack & (cnt == TMO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (req_ok && !dm_ack)   state_nxt = BUSY;
            BUSY: if (dm_ack || tmo_hit)   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        dm_req   = 1'b0;
        dm_we    = 1'b0;
        dm_addr  = '0;
        dm_wdata = '0;
        stall    = 1'b0;
        latch_en = 1'b0;
        err_set  = 1'b0;
        res_nxt  = '0;
        rd_nxt   = '0;
        regw_nxt = 1'b0;
        case (state)
            IDLE: begin
                dm_req   = req_ok;
                dm_we    = memwi & req_ok;
                dm_addr  = {alui[31:2], 2'b00};
                dm_wdata = wdi;
                if (misal) begin
                    err_set = 1'b1;
                end else if (req_ok && !dm_ack) begin
                    stall    = 1'b1;
                    latch_en = 1'b1;
                end else begin
                    res_nxt  = wb_sel(resrci, alui, dm_rdata, pcp4i);
                    rd_nxt   = rdi;
                    regw_nxt = regwi;
                end
            end
            BUSY: begin
                dm_req   = 1'b1;
                dm_we    = we_p1;
                dm_addr  = addr_p1;
                dm_wdata = wdata_p1;
                stall    = ~dm_ack & ~tmo_hit;
                err_set  = tmo_hit;
                if (dm_ack) begin
                    res_nxt  = wb_sel(resrc_p1, addr_p1, dm_rdata, pcp4_p1);
                    rd_nxt   = rd_p1;
                    regw_nxt = regw_p1;
                end
            end
        endcase
        // Drop the request the instant reset asserts, even mid-access.
        if (!rst_n) begin
            dm_req = 1'b0;
            dm_we  = 1'b0;
            stall  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)             cnt <= '0;
        else if (state == BUSY) cnt <= cnt + 8'd1;
        else                    cnt <= '0;
    end

    // Request capture: held stable for the whole BUSY period
    always_ff @(posedge clk) begin
        if (latch_en) begin
            addr_p1  <= {alui[31:2], 2'b00};
            wdata_p1 <= wdi;
            pcp4_p1  <= pcp4i;
            we_p1    <= memwi;
            rd_p1    <= rdi;
            regw_p1  <= regwi;
            resrc_p1 <= resrci;
        end
    end

    // MEM/WB register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resulto <= '0;
            rdo     <= '0;
            regwo   <= 1'b0;
            err     <= 1'b0;
        end else begin
            resulto <= res_nxt;
            rdo     <= rd_nxt;
            regwo   <= regw_nxt;
            err     <= err | err_set;
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Randomized scoreboard bench for mem_wb_stage: driver pushes per-cycle expected
// writeback state, a monitor pops and compares after every rising edge.
module tb_mem_wb_stage;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] alui, wdi, pcp4i, dm_rdata;
    logic [4:0]  rdi;
    logic        regwi, memwi, dm_ack;
    logic [1:0]  resrci;
    logic        dm_req, dm_we, stall, regwo, err;
    logic [31:0] dm_addr, dm_wdata, resulto;
    logic [4:0]  rdo;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        logic        regw;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    logic err_m  = 1'b0;

    mem_wb_stage #(.TMO_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .alui(alui), .wdi(wdi), .pcp4i(pcp4i),
        .rdi(rdi), .regwi(regwi), .memwi(memwi), .resrci(resrci),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ack(dm_ack), .stall(stall),
        .resulto(resulto), .rdo(rdo), .regwo(regwo), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] sel(input logic [1:0] s, input logic [31:0] a,
                                        input logic [31:0] r, input logic [31:0] p);
        case (s)
            2'b00:   return a;
            2'b01:   return r;
            2'b10:   return p;
            default: return 32'h0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic push(input logic [31:0] res, input logic [4:0] rd, input logic regw);
        exp_t e;
        e.res = res; e.rd = rd; e.regw = regw; e.err = err_m;
        exp_q.push_back(e);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if ({resulto, rdo, regwo, err} !== {e.res, e.rd, e.regw, e.err}) begin
                errors++;
                $display("FAIL wb: got res=0x%08h rd=%0d regw=%0b err=%0b expected res=0x%08h rd=%0d regw=%0b err=%0b at %0t",
                         resulto, rdo, regwo, err, e.res, e.rd, e.regw, e.err, $time);
            end
        end
    end

    // lat: cycle of the access in which ack arrives (0 = same cycle); above TMO never completes.
    task automatic run_op(input logic [31:0] alu, input logic [31:0] wd, input logic [31:0] pc,
                          input logic [4:0] rd, input logic regw, input logic memw,
                          input logic [1:0] rsel, input int lat, input logic [31:0] rdv);
        logic acc, mis, ack, tmo;
        logic [31:0] rdata;
        acc = memw | (rsel == 2'b01);
        mis = acc && (alu[1:0] != 2'b00);
        @(negedge clk);
        alui = alu; wdi = wd; pcp4i = pc; rdi = rd; regwi = regw; memwi = memw; resrci = rsel;
        if (!acc || mis) begin
            dm_ack   = 1'($urandom_range(0, 1));
            dm_rdata = $urandom;
            if (mis) begin
                err_m = 1'b1;
                push(32'h0, 5'd0, 1'b0);
            end else begin
                push(sel(rsel, alu, 32'h0, pc), rd, regw);
            end
            #1;
            chk("idle_req", {31'd0, dm_req}, 32'd0);
            chk("idle_stall", {31'd0, stall}, 32'd0);
        end else begin
            for (int c = 0; c <= TMO; c++) begin
                if (c > 0) begin
                    @(negedge clk);
                    alui = $urandom; wdi = $urandom; pcp4i = $urandom; rdi = 5'($urandom);
                    regwi = 1'($urandom); memwi = 1'($urandom); resrci = 2'($urandom);
                end
                ack   = (c == lat);
                tmo   = !ack && (c == TMO);
                rdata = ack ? rdv : $urandom;
                dm_ack = ack; dm_rdata = rdata;
                if (ack) push(sel(rsel, alu, rdata, pc), rd, regw);
                else begin
                    if (tmo) err_m = 1'b1;
                    push(32'h0, 5'd0, 1'b0);
                end
                #1;
                chk("acc_req", {31'd0, dm_req}, 32'd1);
                chk("acc_we", {31'd0, dm_we}, {31'd0, memw});
                chk("acc_addr", dm_addr, alu);
                chk("acc_wdata", dm_wdata, wd);
                chk("acc_stall", {31'd0, stall}, {31'd0, !ack && !tmo});
                if (ack || tmo) break;
            end
        end
    endtask

    initial begin
        logic [31:0] a;
        logic [1:0]  rs;
        logic        mw;
        int          kind;
        rst_n = 1'b0; alui = 0; wdi = 0; pcp4i = 0; rdi = 0; regwi = 0; memwi = 0;
        resrci = 0; dm_ack = 0; dm_rdata = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_res", resulto, 32'h0);
        chk("rst_rd", {27'd0, rdo}, 32'd0);
        chk("rst_regw", {31'd0, regwo}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_req", {31'd0, dm_req}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(32'h10, 32'h0, 32'h4, 5'd5, 1'b1, 1'b0, 2'b00, 0, 32'h0);
        run_op(32'h100, 32'h0, 32'h8, 5'd7, 1'b1, 1'b0, 2'b01, 0, 32'hDEADBEEF);
        run_op(32'h200, 32'h1234, 32'hC, 5'd0, 1'b0, 1'b1, 2'b00, 3, 32'h0);
        run_op(32'h0, 32'h0, 32'h20, 5'd2, 1'b1, 1'b0, 2'b10, 0, 32'h0);
        run_op(32'h0, 32'h0, 32'h20, 5'd3, 1'b1, 1'b0, 2'b11, 0, 32'h0);
        run_op(32'h300, 32'h55, 32'h0, 5'd4, 1'b1, 1'b1, 2'b01, 2, 32'hA5A5A5A5);
        run_op(32'h400, 32'h0, 32'h0, 5'd6, 1'b1, 1'b0, 2'b01, TMO, 32'h600DF00D);
        chk("err_before_tmo", {31'd0, err}, 32'd0);
        run_op(32'h500, 32'h0, 32'h0, 5'd8, 1'b1, 1'b0, 2'b01, 100, 32'h0);
        run_op(32'h20, 32'h0, 32'h0, 5'd9, 1'b1, 1'b0, 2'b00, 0, 32'h0);
        run_op(32'h102, 32'h0, 32'h0, 5'd7, 1'b1, 1'b0, 2'b01, 0, 32'h0);

        for (int i = 0; i < 200; i++) begin
            kind = int'($urandom_range(0, 9));
            a  = $urandom;
            mw = (kind >= 7);
            rs = (kind < 4) ? ((kind == 0) ? 2'b00 : (kind == 1) ? 2'b10 :
                               (kind == 2) ? 2'b11 : 2'b00)
                            : (kind < 7) ? 2'b01 : 2'($urandom);
            if ($urandom_range(0, 9) != 0) a[1:0] = 2'b00;
            run_op(a, $urandom, $urandom, 5'($urandom), 1'($urandom), mw, rs,
                   int'($urandom_range(0, TMO + 2)), $urandom);
        end

        // Reset during an outstanding load, then a late ack alongside an ALU op.
        @(negedge clk);
        alui = 32'h300; rdi = 5'd9; regwi = 1'b1; memwi = 1'b0; resrci = 2'b01; dm_ack = 1'b0;
        push(32'h0, 5'd0, 1'b0);
        @(negedge clk);
        push(32'h0, 5'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        err_m = 1'b0;
        #1;
        chk("rst_mid_req", {31'd0, dm_req}, 32'd0);
        chk("rst_mid_stall", {31'd0, stall}, 32'd0);
        chk("rst_mid_res", resulto, 32'h0);
        chk("rst_mid_regw", {31'd0, regwo}, 32'd0);
        chk("rst_mid_err", {31'd0, err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        alui = 32'h44; rdi = 5'd3; regwi = 1'b1; memwi = 1'b0; resrci = 2'b00;
        dm_ack = 1'b1; dm_rdata = 32'hBAD0BAD0;
        push(32'h44, 5'd3, 1'b1);
        #1;
        chk("late_ack_req", {31'd0, dm_req}, 32'd0);
        chk("late_ack_stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        dm_ack = 1'b0;
        @(posedge clk);
        #2;
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
